// File: rtl/dlbf_master_ram_reader.sv
// Replays a host-preloaded RAM as an AXI4-Stream master: niter packets of block_len beats.
// Read latency and backpressure are absorbed by a credit-controlled first-word-fall-through FIFO.
module dlbf_master_ram_reader #(
  parameter int TDATA_WIDTH      = 64,
  parameter int TKEEP_WIDTH      = 8,
  parameter int ADDR_WIDTH       = 16,
  parameter int RAM_READ_LATENCY = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                   m_axis_clk,
  input  logic                   master_rst_n,
  input  logic                   start,
  input  logic [11:0]            niter,
  input  logic [15:0]            block_len,
  output logic                   ram_en,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic [TDATA_WIDTH-1:0] ram_dout,
  output logic                   m_axis_tvalid,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   txdone,
  output logic [3:0]             current_state_wire,
  output logic [15:0]            txram_counter_wire
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] S_IDLE  = 4'h1;
  localparam logic [3:0] S_RUN   = 4'h2;
  localparam logic [3:0] S_DRAIN = 4'h4;
  localparam logic [3:0] S_DONE  = 4'h8;
  localparam logic [PW:0] ONE    = 1;

  logic [1:0]                  r_rst_sync;
  logic                        w_rst_n;
  logic [3:0]                  r_state;
  logic [11:0]                 r_niter;
  logic [15:0]                 r_block_len;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [11:0]                 r_issue_iter;
  logic                        r_ram_en;
  logic [ADDR_WIDTH-1:0]       r_ram_addr;
  logic                        r_ram_last;
  logic [RAM_READ_LATENCY-1:0] r_tag_vld;
  logic [RAM_READ_LATENCY-1:0] r_tag_last;
  logic [PW:0]                 r_inflight;
  logic [TDATA_WIDTH:0]        r_fifo_mem [FIFO_DEPTH];
  logic [PW:0]                 r_wr_ptr;
  logic [PW:0]                 r_rd_ptr;
  logic [15:0]                 r_txcnt;

  logic [PW:0]          w_fifo_count;
  logic [PW+1:0]        w_occ;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_issue;
  logic                 w_issue_last;
  logic                 w_start_ok;
  logic                 w_push;
  logic                 w_pop;
  logic [TDATA_WIDTH:0] w_head;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge m_axis_clk or negedge master_rst_n) begin
    if (!master_rst_n) r_rst_sync <= 2'b00;
    else               r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_fifo_count = r_wr_ptr - r_rd_ptr;
  assign w_empty      = (w_fifo_count == '0);
  assign w_full       = (w_fifo_count == (PW+1)'(FIFO_DEPTH));
  // Credit counts FIFO entries plus every read not yet returned, so a push can never find the FIFO full.
  assign w_occ        = {1'b0, w_fifo_count} + {1'b0, r_inflight};
  assign w_issue      = (r_state == S_RUN) && (w_occ < (PW+2)'(FIFO_DEPTH));
  assign w_issue_last = (r_addr == ADDR_WIDTH'(r_block_len - 16'd1));
  assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                        (niter != 12'd0) && (block_len != 16'd0);
  assign w_push       = r_tag_vld[RAM_READ_LATENCY-1];
  assign w_pop        = !w_empty && m_axis_tready;
  assign w_head       = r_fifo_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge m_axis_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_niter      <= '0;
      r_block_len  <= '0;
      r_addr       <= '0;
      r_issue_iter <= '0;
    end else if (w_start_ok) begin
      r_state      <= S_RUN;
      r_niter      <= niter;
      r_block_len  <= block_len;
      r_addr       <= '0;
      r_issue_iter <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_issue) begin
            if (w_issue_last) begin
              r_addr       <= '0;
              r_issue_iter <= r_issue_iter + 12'd1;
              if (r_issue_iter + 12'd1 == r_niter) r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: if (r_inflight == '0 && w_empty) r_state <= S_DONE;
        default: ;
      endcase
    end
  end

  // Issue stage: registered RAM request plus its tag pipeline aligned to the RAM latency.
  always_ff @(posedge m_axis_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_last <= 1'b0;
      r_tag_vld  <= '0;
      r_tag_last <= '0;
    end else begin
      r_ram_en   <= w_issue;
      r_ram_last <= w_issue && w_issue_last;
      if (w_issue) r_ram_addr <= r_addr;
      r_tag_vld[0]  <= r_ram_en;
      r_tag_last[0] <= r_ram_last;
      for (int i = 1; i < RAM_READ_LATENCY; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
    end
  end

  always_ff @(posedge m_axis_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_txcnt    <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + ONE;
        2'b01:   r_inflight <= r_inflight - ONE;
        default: ;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE;
      if (w_start_ok) r_txcnt <= '0;
      else if (w_pop) r_txcnt <= r_txcnt + 16'd1;
    end
  end

  always_ff @(posedge m_axis_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr[PW-1:0]] <= {r_tag_last[RAM_READ_LATENCY-1], ram_dout};
  end

  a_no_overflow: assert property (@(posedge m_axis_clk) disable iff (!w_rst_n) !(w_push && w_full));

  assign ram_en             = r_ram_en;
  assign ram_addr           = r_ram_addr;
  assign m_axis_tvalid      = !w_empty;
  assign m_axis_tdata       = w_empty ? '0 : w_head[TDATA_WIDTH-1:0];
  assign m_axis_tlast       = !w_empty && w_head[TDATA_WIDTH];
  assign m_axis_tkeep       = '1;
  assign txdone             = (r_state == S_DONE);
  assign current_state_wire = r_state;
  assign txram_counter_wire = r_txcnt;
endmodule

// File: tb/tb_dlbf_master_ram_reader.sv
// Directed bench: RAM model, scoreboard queue of expected beats, immediate-assertion checks.
module tb_dlbf_master_ram_reader;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] niter;
  logic [15:0] block_len;
  logic        ram_en;
  logic [15:0] ram_addr;
  logic [63:0] ram_dout;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tready;
  logic        txdone;
  logic [3:0]  state;
  logic [15:0] txcnt;

  dlbf_master_ram_reader dut (
    .m_axis_clk(clk), .master_rst_n(rst_n), .start(start), .niter(niter),
    .block_len(block_len), .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .txdone(txdone),
    .current_state_wire(state), .txram_counter_wire(txcnt)
  );

  always #5 clk = ~clk;

  logic [63:0] ram_mem [256];
  logic [63:0] rp [L];
  always_ff @(posedge clk) begin
    rp[0] <= ram_mem[ram_addr[7:0]];
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign ram_dout = rp[L-1];

  int          nvec = 0;
  int          nerr = 0;
  logic [64:0] exp_q[$];
  int          beats, lasts;
  logic [15:0] maxaddr;
  bit          en_seen;
  bit          rnd_en = 1'b0;
  bit          stall_pending = 1'b0;
  logic [64:0] stall_word;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, address bound tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (ram_en) begin
        en_seen = 1'b1;
        if (ram_addr > maxaddr) maxaddr = ram_addr;
      end
      if (stall_pending) begin
        check("stall_valid", 65'(tvalid), 65'd1);
        check("stall_data", {tlast, tdata}, stall_word);
      end
      stall_pending = tvalid && !tready;
      stall_word    = {tlast, tdata};
      if (tvalid && tready) begin
        beats++;
        if (tlast) lasts++;
        if (exp_q.size() == 0) check("extra_beat", 65'd1, 65'd0);
        else check("beat", {tlast, tdata}, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) tready = ($urandom_range(0, 9) >= 3);
  end

  task automatic apply_run(input int n, input int bl, input bit push);
    niter = n[11:0];
    block_len = bl[15:0];
    beats = 0; lasts = 0; maxaddr = '0; en_seen = 1'b0;
    if (push)
      for (int it = 0; it < n; it++)
        for (int a = 0; a < bl; a++) exp_q.push_back({a == bl - 1, ram_mem[a]});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_run(input int n, input int bl, input int budget);
    int k = 0;
    while (!txdone && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("txdone", 65'(txdone), 65'd1);
    check("txcnt", 65'(txcnt), 65'(n * bl));
    check("beats", 65'(beats), 65'(n * bl));
    check("tlasts", 65'(lasts), 65'(n));
    check("q_empty", 65'(exp_q.size()), 65'd0);
    check("max_addr", 65'(maxaddr), 65'(bl - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = {16'hA0A0, i[15:0], 16'h5A5A, 16'(i * 3 + 1)};
    rst_n = 1'b0; start = 1'b0; niter = '0; block_len = '0; tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 65'(state), 65'h1);
    check("rst_ram_en", 65'(ram_en), 65'd0);
    check("rst_ram_addr", 65'(ram_addr), 65'd0);
    check("rst_tvalid", 65'(tvalid), 65'd0);
    check("rst_tlast", 65'(tlast), 65'd0);
    check("rst_tdata", 65'(tdata), 65'd0);
    check("rst_txdone", 65'(txdone), 65'd0);
    check("rst_txcnt", 65'(txcnt), 65'd0);
    check("tkeep", 65'(tkeep), 65'hFF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Degenerate starts are ignored.
    apply_run(0, 4, 1'b0);
    repeat (10) @(negedge clk);
    apply_run(2, 0, 1'b0);
    repeat (10) @(negedge clk);
    check("degen_state", 65'(state), 65'h1);
    check("degen_ram_en", 65'(en_seen), 65'd0);
    check("degen_txdone", 65'(txdone), 65'd0);

    apply_run(2, 1, 1'b1);
    finish_run(2, 1, 100);

    // Basic run with latency and no-bubble checks.
    apply_run(1, 4, 1'b1);
    @(negedge clk) check("lat_ram_en_T", 65'(ram_en), 65'd0);
    @(negedge clk) check("lat_ram_en_T1", 65'(ram_en), 65'd1);
    repeat (4) @(negedge clk);
    check("lat_tvalid_T5", 65'(tvalid), 65'd0);
    @(negedge clk) check("lat_tvalid_T6", 65'(tvalid), 65'd1);
    for (int i = 0; i < 3; i++) @(negedge clk) check("no_bubble", 65'(tvalid), 65'd1);
    finish_run(1, 4, 100);

    apply_run(3, 5, 1'b1);
    finish_run(3, 5, 200);

    // Backpressure.
    rnd_en = 1'b1;
    apply_run(2, 16, 1'b1);
    finish_run(2, 16, 2000);
    rnd_en = 1'b0;
    @(posedge clk) #2 tready = 1'b1;

    // Restart from DONE, with a start during RUN that must be ignored.
    apply_run(1, 2, 1'b1);
    @(negedge clk);
    check("restart_txdone", 65'(txdone), 65'd0);
    check("restart_txcnt", 65'(txcnt), 65'd0);
    check("restart_state", 65'(state), 65'h2);
    @(negedge clk);
    niter = 12'd5; block_len = 16'd5; start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    finish_run(1, 2, 100);

    // Reset in the middle of a 32-beat run.
    apply_run(1, 32, 1'b1);
    for (int k = 0; k < 200 && beats < 6; k++) @(negedge clk);
    check("pre_reset_beats", 65'(beats), 65'd6);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 65'(tvalid), 65'd0);
    check("midrst_ram_en", 65'(ram_en), 65'd0);
    check("midrst_txdone", 65'(txdone), 65'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_state", 65'(state), 65'h1);
    check("post_rst_tvalid", 65'(tvalid), 65'd0);
    apply_run(1, 32, 1'b1);
    finish_run(1, 32, 300);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
